sram_bist_ctrl: RTL and testbench

March C- built-in self-test sequencer that sits directly upstream of the `sram22_64x4m4w2` macro. It drives the SRAM's `we`/`wmask`/`addr`/`din` pins and checks `dout`, so the macro can be exercised and characterised without an external pattern source. A single `start` pulse runs the full march. The block then reports pass/fail and, optionally, diagnostic capture of the first miscompare.

---
 rtl/sram_bist_pkg.sv | 46 ++++
 rtl/sram_bist_ctrl_if.sv | 15 +
 rtl/sram_bist_cmp.sv | 80 ++++++++
 rtl/sram_bist_ctrl.sv | 114 +++++++++++
 tb/tb_sram_bist_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types for the March C- SRAM BIST: sequencer states and the
// per-element constant table (direction, op pattern, read/write data).
package sram_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_M5,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_W,
        OP_RW,
        OP_R
    } op_t;

    typedef struct packed {
        logic desc;    // 1: walk DEPTH-1 down to 0
        op_t  op;
        logic rd_one;  // expected read data is all-ones
        logic wr_one;  // write data is all-ones
    } elem_t;

    function automatic elem_t elem_cfg(input state_t s);
        elem_t e;
        e = '{1'b0, OP_NONE, 1'b0, 1'b0};
        case (s)
            ST_M0:   e = '{1'b0, OP_W,  1'b0, 1'b0};
            ST_M1:   e = '{1'b0, OP_RW, 1'b0, 1'b1};
            ST_M2:   e = '{1'b0, OP_RW, 1'b1, 1'b0};
            ST_M3:   e = '{1'b1, OP_RW, 1'b0, 1'b1};
            ST_M4:   e = '{1'b1, OP_RW, 1'b1, 1'b0};
            ST_M5:   e = '{1'b0, OP_R,  1'b0, 1'b0};
            default: e = '{1'b0, OP_NONE, 1'b0, 1'b0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sram_bist_ctrl_if.sv
// SRAM pin bundle between the BIST sequencer (master) and the macro (slave).
interface sram_bist_ctrl_if #(
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = 2
);
    logic                   we;
    logic [WMASK_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  din;
    logic [DATA_WIDTH-1:0]  dout;

    modport master (output we, output wmask, output addr, output din, input dout);
    modport slave  (input we, input wmask, input addr, input din, output dout);
endinterface

// File: rtl/sram_bist_cmp.sv
// Read-data checker: registers the expected word, compares it against dout a
// cycle later, keeps pass; error log exists only with SRAM_BIST_ERR_LOG_EN.
module sram_bist_cmp #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_exp,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  fail_cnt,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act
);
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] exp_p1;
    logic                  miss_p1;

    assign miss_p1 = vld_p1 && (dout != exp_p1);

    // Stage p1: dout of the previous read is valid here
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            pass   <= 1'b0;
        end else begin
            vld_p1 <= rd;
            if (clr)
                pass <= 1'b1;
            else if (miss_p1)
                pass <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        exp_p1 <= rd_exp;
    end

`ifdef SRAM_BIST_ERR_LOG_EN
    logic [ADDR_WIDTH-1:0] addr_p1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clock) begin
        addr_p1 <= rd_addr;
    end

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            fail_cnt  <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
        end else if (miss_p1) begin
            fail_cnt <= sat_inc(fail_cnt);
            if (fail_cnt == '0) begin
                fail_addr <= addr_p1;
                fail_exp  <= exp_p1;
                fail_act  <= dout;
            end
        end
    end
`else
    logic unused_addr;
    assign unused_addr = ^rd_addr;
    assign fail_cnt    = '0;
    assign fail_addr   = '0;
    assign fail_exp    = '0;
    assign fail_act    = '0;
`endif

endmodule

// File: rtl/sram_bist_ctrl.sv
// March C- BIST sequencer for the sram22_64x4m4w2 macro: FSM, address counter
// and read checker. Error log (fail_*) built only with SRAM_BIST_ERR_LOG_EN.
module sram_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  fail_cnt,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act,
    sram_bist_ctrl_if.master      sram
);
    state_t                state, nxt_state;
    logic                  phase, nxt_phase;   // 1: write half of a read-write pair
    logic [ADDR_WIDTH-1:0] addr, nxt_addr;
    logic                  we_q, nxt_we;
    logic [DATA_WIDTH-1:0] din_q, nxt_din;
    elem_t                 cur, succ, nxt;
    logic                  start_ok, addr_last, rd_now;
    logic [DATA_WIDTH-1:0] rd_exp;

    always_comb begin
        cur       = elem_cfg(state);
        succ      = elem_cfg(state_t'(state + 4'd1));
        start_ok  = start && (state == ST_IDLE || state == ST_DONE);
        addr_last = cur.desc ? (addr == '0) : (addr == '1);
        rd_now    = (cur.op == OP_R) || (cur.op == OP_RW && !phase);
        rd_exp    = {DATA_WIDTH{cur.rd_one}};
        nxt_state = state;
        nxt_phase = 1'b0;
        nxt_addr  = addr;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    nxt_state = ST_M0;
                    nxt_addr  = '0;
                end
            end
            ST_DRAIN: begin
                nxt_state = ST_DONE;
                nxt_addr  = '0;
            end
            default: begin
                if (cur.op == OP_RW && !phase) begin
                    nxt_phase = 1'b1;
                end else if (addr_last) begin
                    nxt_state = state_t'(state + 4'd1);
                    nxt_addr  = {ADDR_WIDTH{succ.desc}};
                end else begin
                    nxt_addr = cur.desc ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
                end
            end
        endcase
        // Pin values are registered, so they follow the state being entered
        nxt     = elem_cfg(nxt_state);
        nxt_we  = (nxt.op == OP_W) || (nxt.op == OP_RW && nxt_phase);
        nxt_din = {DATA_WIDTH{nxt_we && nxt.wr_one}};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            phase <= 1'b0;
            addr  <= '0;
            we_q  <= 1'b0;
            din_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt_state;
            phase <= nxt_phase;
            addr  <= nxt_addr;
            we_q  <= nxt_we;
            din_q <= nxt_din;
            busy  <= (nxt_state != ST_IDLE) && (nxt_state != ST_DONE);
            done  <= (nxt_state == ST_DONE);
        end
    end

    assign sram.we    = we_q;
    assign sram.wmask = '1;
    assign sram.addr  = addr;
    assign sram.din   = din_q;

    sram_bist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_cmp (
        .clock     (clock),
        .reset     (reset),
        .clr       (start_ok),
        .rd        (rd_now),
        .rd_addr   (addr),
        .rd_exp    (rd_exp),
        .dout      (sram.dout),
        .pass      (pass),
        .fail_cnt  (fail_cnt),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act)
    );

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: SRAM model with injectable stuck-at faults, a
// march-level reference model, directed table, random faults and corner sequences.
module tb_sram_bist_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;

    always #5 clock = ~clock;

    sram_bist_ctrl_if #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2)) sif ();
    sram_bist_ctrl_if #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2)) sif2 ();

    logic       busy, done, pass;
    logic [7:0] fail_cnt;
    logic [5:0] fail_addr;
    logic [3:0] fail_exp, fail_act;

    logic       busy2, done2, pass2;
    logic [1:0] fail_cnt2;
    logic [5:0] fail_addr2;
    logic [3:0] fail_exp2, fail_act2;

    sram_bist_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2), .CNT_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
        .sram(sif)
    );

    sram_bist_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2), .CNT_WIDTH(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2),
        .busy(busy2), .done(done2), .pass(pass2),
        .fail_cnt(fail_cnt2), .fail_addr(fail_addr2), .fail_exp(fail_exp2), .fail_act(fail_act2),
        .sram(sif2)
    );

    // SRAM model: synchronous write, one-cycle read latency, stuck-at fault on read port
    logic [3:0] mem [64];
    logic [3:0] rd_raw;
    logic [5:0] rd_a;
    logic       flt_en = 1'b0;
    logic [5:0] flt_addr = '0;
    logic [3:0] flt_mask = '0;
    logic [3:0] flt_val = '0;

    always @(posedge clock) begin
        if (sif.we) mem[sif.addr] <= sif.din;
        rd_raw <= mem[sif.addr];
        rd_a   <= sif.addr;
    end

    assign sif.dout  = (flt_en && rd_a == flt_addr) ? ((rd_raw & ~flt_mask) | (flt_val & flt_mask)) : rd_raw;
    assign sif2.dout = 4'h0;   // every bit of every address stuck at 0

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic [3:0] din;
    } pin_t;

    pin_t       exp_q[$];
    int         m_cnt;
    logic       m_pass;
    logic [5:0] m_addr;
    logic [3:0] m_exp, m_act;

    typedef struct {
        logic       en;
        logic [5:0] fa;
        logic [3:0] fm;
        logic [3:0] fv;
        logic       e_pass;
        logic [7:0] e_cnt;
        logic [5:0] e_addr;
        logic [3:0] e_exp;
        logic [3:0] e_act;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // March C- reference: per-cycle pin sequence and the expected error log
    task automatic build_model(input logic en, input logic [5:0] fa, input logic [3:0] fm, input logic [3:0] fv);
        logic [3:0] ref_mem [64];
        logic [3:0] got, rv, wv;
        bit         desc, rd, wr;
        int         a;
        exp_q.delete();
        m_cnt  = 0;
        m_addr = '0;
        m_exp  = '0;
        m_act  = '0;
        for (int e = 0; e < 6; e++) begin
            desc = (e == 3 || e == 4);
            rd   = (e > 0);
            wr   = (e < 5);
            rv   = (e == 2 || e == 4) ? 4'hF : 4'h0;
            wv   = (e == 1 || e == 3) ? 4'hF : 4'h0;
            for (int i = 0; i < 64; i++) begin
                a = desc ? 63 - i : i;
                if (rd) begin
                    exp_q.push_back('{1'b0, 6'(a), 4'h0});
                    got = ref_mem[a];
                    if (en && 6'(a) == fa) got = (got & ~fm) | (fv & fm);
                    if (got != rv) begin
                        if (m_cnt == 0) begin
                            m_addr = 6'(a);
                            m_exp  = rv;
                            m_act  = got;
                        end
                        m_cnt++;
                    end
                end
                if (wr) begin
                    exp_q.push_back('{1'b1, 6'(a), wv});
                    ref_mem[a] = wv;
                end
            end
        end
        exp_q.push_back('{1'b0, 6'h0, 4'h0});   // drain cycle
        m_pass = (m_cnt == 0);
    endtask

    // Checks the 641 busy cycles following the start edge against exp_q
    task automatic check_pins(input string nm);
        logic bad;
        bad = 1'b0;
        for (int c = 1; c <= 641; c++) begin
            @(negedge clock);
            if (!bad && (busy !== 1'b1 || done !== 1'b0 || sif.wmask !== 2'b11 ||
                         sif.we !== exp_q[c-1].we || sif.din !== exp_q[c-1].din ||
                         (c < 641 && sif.addr !== exp_q[c-1].addr))) begin
                bad = 1'b1;
                $display("FAIL %s pins cycle %0d: busy=%b done=%b wmask=%b we=%b addr=%0h din=%0h, expected busy=1 done=0 wmask=11 we=%b addr=%0h din=%0h",
                         nm, c, busy, done, sif.wmask, sif.we, sif.addr, sif.din,
                         exp_q[c-1].we, exp_q[c-1].addr, exp_q[c-1].din);
            end
        end
        checks++;
        if (bad) errors++;
    endtask

    task automatic run_check(input string nm, input logic e_pass, input logic [7:0] e_cnt,
                             input logic [5:0] e_addr, input logic [3:0] e_exp, input logic [3:0] e_act);
`ifndef SRAM_BIST_ERR_LOG_EN
        e_cnt  = '0;
        e_addr = '0;
        e_exp  = '0;
        e_act  = '0;
`endif
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        check_pins(nm);
        @(negedge clock);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " pass"}, 32'(pass), 32'(e_pass));
        chk({nm, " fail_cnt"}, 32'(fail_cnt), 32'(e_cnt));
        chk({nm, " fail_addr"}, 32'(fail_addr), 32'(e_addr));
        chk({nm, " fail_exp"}, 32'(fail_exp), 32'(e_exp));
        chk({nm, " fail_act"}, 32'(fail_act), 32'(e_act));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[4];
        int         dc;
        logic [1:0] sat_cnt_exp;
        logic [5:0] sat_addr_exp;
        logic [3:0] sat_exp_exp;

        tbl[0] = '{1'b0, 6'h00, 4'h0, 4'h0, 1'b1, 8'd0, 6'h00, 4'h0, 4'h0};  // fault-free
        tbl[1] = '{1'b1, 6'h15, 4'h1, 4'h1, 1'b0, 8'd3, 6'h15, 4'h0, 4'h1};  // bit0 SA1
        tbl[2] = '{1'b1, 6'h2A, 4'h8, 4'h0, 1'b0, 8'd2, 6'h2A, 4'hF, 4'h7};  // bit3 SA0
        tbl[3] = '{1'b1, 6'h3F, 4'hF, 4'h0, 1'b0, 8'd2, 6'h3F, 4'hF, 4'h0};  // word SA0

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst pass", 32'(pass), 32'd0);
        chk("rst we", 32'(sif.we), 32'd0);
        chk("rst addr", 32'(sif.addr), 32'd0);
        chk("rst din", 32'(sif.din), 32'd0);
        chk("rst wmask", 32'(sif.wmask), 32'h3);
        chk("rst fail_cnt", 32'(fail_cnt), 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            flt_en   = tbl[i].en;
            flt_addr = tbl[i].fa;
            flt_mask = tbl[i].fm;
            flt_val  = tbl[i].fv;
            build_model(tbl[i].en, tbl[i].fa, tbl[i].fm, tbl[i].fv);
            run_check($sformatf("tbl%0d", i), tbl[i].e_pass, tbl[i].e_cnt,
                      tbl[i].e_addr, tbl[i].e_exp, tbl[i].e_act);
        end

        for (int i = 0; i < 6; i++) begin
            flt_en   = 1'b1;
            flt_addr = 6'($urandom_range(0, 63));
            flt_mask = 4'($urandom_range(1, 15));
            flt_val  = 4'($urandom_range(0, 15));
            build_model(flt_en, flt_addr, flt_mask, flt_val);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            run_check($sformatf("rand%0d", i), m_pass, (m_cnt > 255) ? 8'hFF : 8'(m_cnt),
                      m_addr, m_exp, m_act);
        end

        // Reset in the middle of M2
        flt_en = 1'b0;
        build_model(1'b0, 6'h0, 4'h0, 4'h0);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int c = 1; c <= 199; c++) @(negedge clock);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst we", 32'(sif.we), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst pass", 32'(pass), 32'd0);
        chk("midrst din", 32'(sif.din), 32'd0);
        run_check("after_rst", 1'b1, 8'd0, 6'h0, 4'h0, 4'h0);

        // Start held high across a whole run
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock);
        check_pins("held");
        @(negedge clock);
        chk("held done@642", 32'(done), 32'd1);
        chk("held busy@642", 32'(busy), 32'd0);
        chk("held pass@642", 32'(pass), 32'd1);
        @(negedge clock);
        chk("held busy@643", 32'(busy), 32'd1);
        chk("held done@643", 32'(done), 32'd0);
        chk("held we@643", 32'(sif.we), 32'd1);
        chk("held addr@643", 32'(sif.addr), 32'd0);
        repeat (58) @(posedge clock);
        #1 start = 1'b0;
        dc = 0;
        for (int c = 701; c <= 1400 && dc == 0; c++) begin
            @(negedge clock);
            if (done) dc = c;
        end
        chk("held second done cycle", 32'(dc), 32'd1284);
        chk("held second pass", 32'(pass), 32'd1);

        // Saturating counter on the CNT_WIDTH=2 instance, all bits stuck at 0
`ifdef SRAM_BIST_ERR_LOG_EN
        sat_cnt_exp  = 2'd3;
        sat_addr_exp = 6'h00;
        sat_exp_exp  = 4'hF;
`else
        sat_cnt_exp  = 2'd0;
        sat_addr_exp = 6'h00;
        sat_exp_exp  = 4'h0;
`endif
        @(posedge clock); #1 start2 = 1'b1;
        @(posedge clock); #1 start2 = 1'b0;
        for (int c = 1; c <= 642; c++) begin
            @(negedge clock);
            if (c == 194) begin
                chk("sat pass@194", 32'(pass2), 32'd1);
                chk("sat cnt@194", 32'(fail_cnt2), 32'd0);
            end
            if (c == 195) begin
                chk("sat pass@195", 32'(pass2), 32'd0);
                chk("sat cnt@195", 32'(fail_cnt2), (sat_cnt_exp != 2'd0) ? 32'd1 : 32'd0);
            end
            if (c == 641) chk("sat busy@641", 32'(busy2), 32'd1);
        end
        chk("sat done", 32'(done2), 32'd1);
        chk("sat busy", 32'(busy2), 32'd0);
        chk("sat pass", 32'(pass2), 32'd0);
        chk("sat fail_cnt", 32'(fail_cnt2), 32'(sat_cnt_exp));
        chk("sat fail_addr", 32'(fail_addr2), 32'(sat_addr_exp));
        chk("sat fail_exp", 32'(fail_exp2), 32'(sat_exp_exp));
        chk("sat fail_act", 32'(fail_act2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
